// File: rtl/pwm_ramp_controller_pkg.sv
// Shared constants for the PWM ramp controller: register map and FSM state codes.
package pwm_ramp_controller_pkg;
  localparam int unsigned REGS_PER_UNIT = 4;

  localparam logic [7:0] REG_PERIOD = 8'd0;
  localparam logic [7:0] REG_ON     = 8'd1;
  localparam logic [7:0] REG_CONFIG = 8'd2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_WR_PERIOD  = 3'd1;
  localparam state_t S_WR_CONFIG  = 3'd2;
  localparam state_t S_WR_ON      = 3'd3;
  localparam state_t S_WAIT_TICK  = 3'd4;
  localparam state_t S_WR_OFF     = 3'd5;
  localparam state_t S_WR_DISABLE = 3'd6;
endpackage

// File: rtl/pwm_ramp_controller_tick.sv
// Ramp step timer: tick pulses on the TICK_DIV-th cycle after restart is released.
module ramp_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  logic [23:0] cnt;

  assign tick = !restart && (cnt == 24'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset || restart || tick) cnt <= '0;
    else                           cnt <= cnt + 24'd1;
  end
endmodule

// File: rtl/pwm_ramp_controller.sv
// Sequences register writes to one pwm_channel: program period/config, then ramp T_on
// one step per tick towards the target, or shut the channel down.
module pwm_ramp_controller
  import pwm_ramp_controller_pkg::*;
#(
  parameter int unsigned PWM_UNIT = 0,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_period,
  input  logic [DATA_W-1:0] cmd_target_on,
  input  logic [15:0]       cmd_step,
  input  logic              cmd_enable,
  input  logic              abort,
  output logic              reg_wr,
  output logic [7:0]        reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] cur_on
);
  localparam logic [7:0] BASE        = 8'(PWM_UNIT * REGS_PER_UNIT);
  localparam logic [7:0] ADDR_PERIOD = BASE + REG_PERIOD;
  localparam logic [7:0] ADDR_ON     = BASE + REG_ON;
  localparam logic [7:0] ADDR_CONFIG = BASE + REG_CONFIG;
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [DATA_W-1:0] target_q;
  logic [15:0]       step_q;
  logic              abort_pend, stop, tick, at_target;
  logic [DATA_W:0]   step_ext, tgt_ext, up_sum, dn_diff;
  logic [DATA_W-1:0] ramp_next;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign stop      = abort_pend || abort;
  assign at_target = (cur_on == target_q);

  // One extra bit so the step can neither wrap above max nor borrow below zero.
  assign step_ext = {{(DATA_W-15){1'b0}}, step_q};
  assign tgt_ext  = {1'b0, target_q};
  assign up_sum   = {1'b0, cur_on} + step_ext;
  assign dn_diff  = {1'b0, cur_on} - step_ext;

  always_comb begin
    ramp_next = target_q;
    if (step_q != '0) begin
      if (cur_on < target_q) begin
        if (up_sum < tgt_ext) ramp_next = up_sum[DATA_W-1:0];
      end else if (!dn_diff[DATA_W] && (dn_diff > tgt_ext)) begin
        ramp_next = dn_diff[DATA_W-1:0];
      end
    end
  end

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (state != S_WAIT_TICK),
    .tick    (tick)
  );

  // Within a write state, reg_wr low means the write has been acked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      done       <= 1'b0;
      cur_on     <= '0;
      target_q   <= '0;
      step_q     <= '0;
      abort_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      if (reg_wr && reg_ack) begin
        reg_wr <= 1'b0;
        if (reg_addr == ADDR_ON) cur_on <= reg_wdata;
      end
      if (abort && (state == S_WR_PERIOD || state == S_WR_CONFIG || state == S_WR_ON))
        abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (cmd_valid) begin
            target_q <= (cmd_target_on > cmd_period) ? cmd_period : cmd_target_on;
            step_q   <= cmd_step;
            reg_wr   <= 1'b1;
            if (cmd_enable) begin
              state     <= S_WR_PERIOD;
              reg_addr  <= ADDR_PERIOD;
              reg_wdata <= cmd_period;
            end else begin
              state     <= S_WR_OFF;
              reg_addr  <= ADDR_ON;
              reg_wdata <= '0;
            end
          end
        end
        S_WR_PERIOD: if (!reg_wr) begin
          if (stop) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state     <= S_WR_CONFIG;
            reg_wr    <= 1'b1;
            reg_addr  <= ADDR_CONFIG;
            reg_wdata <= ONE;
          end
        end
        S_WR_CONFIG: if (!reg_wr) begin
          if (stop || at_target) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state     <= S_WR_ON;
            reg_wr    <= 1'b1;
            reg_addr  <= ADDR_ON;
            reg_wdata <= ramp_next;
          end
        end
        S_WR_ON: if (!reg_wr) begin
          if (stop || step_q == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT_TICK;
          end
        end
        S_WAIT_TICK: begin
          if (abort || (tick && at_target)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else if (tick) begin
            state     <= S_WR_ON;
            reg_wr    <= 1'b1;
            reg_addr  <= ADDR_ON;
            reg_wdata <= ramp_next;
          end
        end
        S_WR_OFF: if (!reg_wr) begin
          state     <= S_WR_DISABLE;
          reg_wr    <= 1'b1;
          reg_addr  <= ADDR_CONFIG;
          reg_wdata <= '0;
        end
        S_WR_DISABLE: if (!reg_wr) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench: write-sequence model plus per-cycle handshake/done/cur_on checks.
module tb_pwm_ramp_controller;
  localparam int TICK_DIV = 4;

  logic        clk, reset, cmd_valid, cmd_ready, cmd_enable, abort;
  logic [31:0] cmd_period, cmd_target_on, reg_wdata, cur_on;
  logic [15:0] cmd_step;
  logic        reg_wr, reg_ack, busy, done;
  logic [7:0]  reg_addr;

  pwm_ramp_controller #(.PWM_UNIT(0), .TICK_DIV(TICK_DIV), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_target_on(cmd_target_on), .cmd_step(cmd_step),
    .cmd_enable(cmd_enable), .abort(abort), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_ack(reg_ack), .busy(busy), .done(done), .cur_on(cur_on)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] on_log[$];
  logic [31:0] lit[$];
  logic [31:0] m_cur;
  int checks = 0, errors = 0;
  int cyc = 0, age = 0, ack_dly = 0, last_on_ack = -1, done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected write list derived directly from the command rules.
  task automatic build(input logic [31:0] p, input logic [31:0] t, input logic [15:0] s,
                       input logic en, input int ab);
    logic [31:0] tt, c;
    int n;
    if (!en) begin
      exp_q.push_back('{8'd1, 32'd0});
      exp_q.push_back('{8'd2, 32'd0});
    end else begin
      exp_q.push_back('{8'd0, p});
      exp_q.push_back('{8'd2, 32'd1});
      tt = (t > p) ? p : t;
      c  = m_cur;
      n  = 0;
      while (c != tt && (ab < 0 || n < ab)) begin
        if (s == 0)      c = tt;
        else if (c < tt) c = ((tt - c) <= 32'(s)) ? tt : c + 32'(s);
        else             c = ((c - tt) <= 32'(s)) ? tt : c - 32'(s);
        exp_q.push_back('{8'd1, c});
        n++;
        if (s == 0) break;
      end
    end
  endtask

  // Compare process + ack responder; everything sampled at the falling edge.
  initial begin
    logic p_rst, p_wr, p_ack, p_busy;
    logic [7:0]  p_addr;
    logic [31:0] p_data;
    wr_t e;
    p_rst = 0; p_wr = 0; p_ack = 0; p_busy = 0; p_addr = 0; p_data = 0;
    m_cur = 0;
    reg_ack = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!p_rst) begin
        m_cur = 0;
        exp_q.delete();
      end else begin
        if (p_wr && p_ack) begin
          if (exp_q.size() == 0) chk("unexpected_write", {p_addr, p_data}, 0);
          else begin
            e = exp_q.pop_front();
            chk("wr_addr", p_addr, e.a);
            chk("wr_data", p_data, e.d);
          end
          if (p_addr == 8'd1) begin
            m_cur = p_data;
            on_log.push_back(p_data);
            last_on_ack = cyc - 1;
          end
          chk("wr_drop_after_ack", reg_wr, 0);
        end else if (p_wr) begin
          chk("wr_hold_stable", {reg_wr, reg_addr, reg_wdata}, {1'b1, p_addr, p_data});
        end
        if (reg_wr && !p_wr && reg_addr == 8'd1 && last_on_ack >= 0)
          chk("tick_gap", cyc - last_on_ack, TICK_DIV + 2);
        chk("cur_on", cur_on, m_cur);
        chk("ready_vs_busy", cmd_ready, !busy);
        chk("done_on_idle_entry", done, p_busy && !busy);
        if (done) done_cnt++;
      end
      p_rst = reset; p_wr = reg_wr; p_addr = reg_addr; p_data = reg_wdata; p_busy = busy;
      if (reset && reg_wr && !reg_ack) begin
        age++;
        if (age > ack_dly) reg_ack = 1'b1;
      end else begin
        reg_ack = 1'b0;
        age = 0;
      end
      p_ack = reg_ack;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic run_cmd(input logic [31:0] p, input logic [31:0] t, input logic [15:0] s,
                         input logic en, input int ab, input int ad);
    int d0, n;
    chk("ready_before_cmd", cmd_ready, 1);
    build(p, t, s, en, ab);
    ack_dly = ad; last_on_ack = -1; on_log.delete(); d0 = done_cnt;
    cmd_period = p; cmd_target_on = t; cmd_step = s; cmd_enable = en; cmd_valid = 1;
    step(1);
    cmd_valid = 0;
    chk("busy_after_accept", busy, 1);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      if (ab >= 0 && on_log.size() >= ab) abort = 1;
      step(1);
      n++;
    end
    abort = 0;
    if (n >= 400) chk("cmd_timeout", 1, 0);
    step(2);
    chk("done_once", done_cnt - d0, 1);
    chk("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_count"}, on_log.size(), lit.size());
    for (int i = 0; i < lit.size() && i < on_log.size(); i++) chk(nm, on_log[i], lit[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; cmd_valid = 0; cmd_enable = 0; abort = 0;
    cmd_period = 0; cmd_target_on = 0; cmd_step = 0;
    step(3);
    chk("rst_outputs", {reg_wr, reg_addr, reg_wdata, busy, done, cur_on}, 0);
    reset = 1;
    step(1);
    chk("ready_after_reset", cmd_ready, 1);

    // Abort while idle has no effect.
    abort = 1; step(2); abort = 0;
    chk("abort_idle_ignored", {busy, cmd_ready}, 2'b01);

    run_cmd(20, 10, 0, 1, -1, 0);
    lit = '{32'd10}; chk_log("jump_on");
    chk("jump_cur_on", cur_on, 10);

    run_cmd(20, 0, 0, 0, -1, 5);
    chk("shutdown_cur_on", cur_on, 0);

    run_cmd(20, 10, 3, 1, -1, 1);
    lit = '{32'd3, 32'd6, 32'd9, 32'd10}; chk_log("ramp_up");

    run_cmd(20, 0, 4, 1, 2, 0);
    lit = '{32'd6, 32'd2}; chk_log("ramp_abort");
    chk("abort_cur_on", cur_on, 2);

    run_cmd(20, 30, 0, 1, -1, 2);
    lit = '{32'd20}; chk_log("clamp");

    run_cmd(20, 5, 7, 1, -1, 0);
    lit = '{32'd13, 32'd6, 32'd5}; chk_log("ramp_down_sat");

    // Reset while waiting for a tick.
    build(20, 15, 1, 1, -1);
    ack_dly = 0; last_on_ack = -1; on_log.delete();
    cmd_period = 20; cmd_target_on = 15; cmd_step = 1; cmd_enable = 1; cmd_valid = 1;
    step(1);
    cmd_valid = 0;
    for (int n = 0; n < 100 && on_log.size() == 0; n++) step(1);
    chk("pre_reset_on_write", on_log.size(), 1);
    step(2);
    reset = 0;
    step(1);
    chk("midtick_rst_outputs", {reg_wr, reg_addr, reg_wdata, busy, done, cur_on}, 0);
    chk("midtick_rst_ready", cmd_ready, 1);
    reset = 1;
    step(3);
    chk("no_strobe_after_reset", {reg_wr, busy}, 0);

    run_cmd(20, 4, 0, 1, -1, 1);
    lit = '{32'd4}; chk_log("after_reset_cmd");
    chk("after_reset_cur_on", cur_on, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 Parameter PWM_UNIT, default 0: index of the controlled pwm_channel; register base = PWM_UNIT*REGS_PER_UNIT.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per ramp step (1 ms at 50 MHz); legal range 2..2^24-1.
REQ-003 Parameter DATA_W, default 32: register data width.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  high only in IDLE; command accepted on cycle with cmd_valid && cmd_ready.
REQ-008 cmd_period  input  DATA_W  target T_period.
REQ-009 cmd_target_on  input  DATA_W  target T_on.
REQ-010 cmd_step  input  16  T_on change per tick; 0 = jump directly.
REQ-011 cmd_enable  input  1  1 = run/ramp channel, 0 = shut channel down.
REQ-012 abort  input  1  stop ramp at next safe point.
REQ-013 reg_wr  output  1  register write strobe, held until reg_ack.
REQ-014 reg_addr  output  8  register number on the shared register bus.
REQ-015 reg_wdata  output  DATA_W  write data.
REQ-016 reg_ack  input  1  write accepted by channel register file.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on return to IDLE after a completed or aborted command.
REQ-019 cur_on  output  DATA_W  last T_on value written to the channel.

Function
REQ-020 States: IDLE, WR_PERIOD, WR_CONFIG, WR_ON, WAIT_TICK, WR_OFF, WR_DISABLE.
REQ-021 On acceptance, inputs are latched; target_on latched as min(cmd_target_on, cmd_period).
REQ-022 cmd_enable=1 path: WR_PERIOD (addr base+0, data period) -> WR_CONFIG (addr base+2, data 1) -> ramp.
REQ-023 Ramp: if cur_on == target -> IDLE; else next = cur_on +/- step, saturated at target (never overshoots, no wrap); WR_ON (addr base+1, data next), then WAIT_TICK.
REQ-024 cmd_step=0: single WR_ON with target, then IDLE.
REQ-025 WAIT_TICK counts TICK_DIV cycles exactly, then evaluates REQ-023 again.
REQ-026 cmd_enable=0 path: WR_OFF (addr base+1, data 0) -> WR_DISABLE (addr base+2, data 0) -> IDLE; cur_on becomes 0.
REQ-027 Write handshake: reg_wr, reg_addr, reg_wdata stable from state entry until cycle where reg_ack=1; reg_wr low the following cycle; at most one write outstanding; no timeout.
REQ-028 cur_on updates in the cycle reg_ack is sampled for a base+1 write.
REQ-029 abort sampled in WAIT_TICK -> IDLE next cycle; abort during a write takes effect after its ack; abort in IDLE ignored.
REQ-030 done asserts the cycle the FSM enters IDLE from any non-IDLE state; cmd_ready rises the same cycle.
REQ-031 Arithmetic in DATA_W+1 bits; step zero-extended.

Reset
REQ-032 reset low at a clk edge: state IDLE, reg_wr=0, reg_addr=0, reg_wdata=0, busy=0, done=0, cur_on=0, tick counter 0; mid-write reset abandons the write with no further strobe.
REQ-033 cmd_ready=1 on first cycle after reset deasserts.

Structure
REQ-034 REGS_PER_UNIT, register offsets (PERIOD=0, ON=1, CONFIG=2) and state enum live in shared global constants package.
REQ-035 One sub-module: ramp_tick_gen (TICK_DIV counter with restart input and single-cycle tick output).

Verification
REQ-036 Reset, period=20, target=10, step=0, enable=1 -> writes (0,20),(2,1),(1,10); done pulse; cur_on=10.
REQ-037 target=10, step=3, TICK_DIV=4 from cur_on=0 -> ON writes 3,6,9,10 spaced by TICK_DIV+ack cycles; no overshoot.
REQ-038 period=20, target=30 -> target clamped, final ON write 20.
REQ-039 Ramp down 10->0 step 4, abort after second write -> writes 6,2 only; done; cur_on=2.
REQ-040 enable=0 with cur_on=10 -> writes (1,0),(2,0); cur_on=0; reg_ack delayed 5 cycles keeps reg_wr/addr/data stable.
REQ-041 reset asserted mid-WAIT_TICK -> all outputs at reset values next cycle; new command accepted after release.
